// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared types and opcodes for the pipelined immediate generator
package imm_gen_pkg;

    localparam int IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_t;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_IMM32  = 7'd27;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_OP     = 7'd51;
    localparam logic [6:0] OP_OP32   = 7'd59;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    // Immediate is always carried at full 64-bit width; the top trims to XLEN.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        fmt_t                 fmt;
        logic                 illegal;
    } entry_t;

    function automatic logic [IMM_MAX_W-1:0] sext32(input logic [31:0] v);
        return {{(IMM_MAX_W-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational opcode decode and immediate assembly
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0] instr,
    output entry_t      entry
);

    logic [6:0]  opcode;
    logic [31:0] imm32;
    fmt_t        fmt;
    logic        illegal;

    assign opcode = instr[6:0];

    // Each 32-bit immediate already carries instr[31] in bit 31, so one
    // final widening step gives true sign extension for every format.
    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b1;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: begin
                imm32   = {{20{instr[31]}}, instr[31:20]};
                fmt     = FMT_I;
                illegal = 1'b0;
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    imm32   = {{20{instr[31]}}, instr[31:20]};
                    fmt     = FMT_I;
                    illegal = 1'b0;
                end
            end
            OP_STORE: begin
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt     = FMT_S;
                illegal = 1'b0;
            end
            OP_BRANCH: begin
                imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
                fmt     = FMT_B;
                illegal = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                imm32   = {instr[31:12], 12'b0};
                fmt     = FMT_U;
                illegal = 1'b0;
            end
            OP_JAL: begin
                imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
                fmt     = FMT_J;
                illegal = 1'b0;
            end
            OP_OP: begin
                fmt     = FMT_R;
                illegal = 1'b0;
            end
            OP_OP32: begin
                if (XLEN == 64) begin
                    fmt     = FMT_R;
                    illegal = 1'b0;
                end
            end
            default: begin
                imm32   = '0;
                fmt     = FMT_NONE;
                illegal = 1'b1;
            end
        endcase
    end

    assign entry.imm     = sext32(imm32);
    assign entry.fmt     = fmt;
    assign entry.illegal = illegal;

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - decoded-immediate output FIFO with illegal-opcode counter
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [ERR_W-1:0] err_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    entry_t           dec_entry;
    entry_t           mem_q [DEPTH];
    entry_t           head;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             push, pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr (instr),
        .entry (dec_entry)
    );

    // Readiness depends only on stored occupancy so a full FIFO never
    // accepts, even when the head is leaving on the same edge.
    assign in_ready  = reset && (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push && dec_entry.illegal && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Payload storage needs no reset: it is only observed when count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec_entry;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign imm       = out_valid ? head.imm[XLEN-1:0] : '0;
    assign fmt       = out_valid ? head.fmt : 3'd0;
    assign illegal   = out_valid ? head.illegal : 1'b0;
    assign err_count = err_q;

endmodule
